// File: rtl/wb_write_arbiter.sv
// Merges in-order WB results and buffered long-unit results onto one register-file write port; one cycle select-to-write latency.
// Long port stalls on a full FIFO (longReady); pipeline stalls only when the aged FIFO head preempts it (pipeReady).
module wb_write_arbiter #(
    parameter int DATA_W       = 32,
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                     clk,
    input  logic                     rstN,
    input  logic                     pipeValid,
    input  logic [4:0]               pipeReg,
    input  logic [DATA_W-1:0]        pipeData,
    output logic                     pipeReady,
    input  logic                     longValid,
    input  logic [4:0]               longReg,
    input  logic [DATA_W-1:0]        longData,
    output logic                     longReady,
    input  logic [4:0]               srcA,
    input  logic [4:0]               srcB,
    output logic                     hazardA,
    output logic                     hazardB,
    output logic [4:0]               writeReg,
    output logic [DATA_W-1:0]        writeData,
    output logic                     regWrite,
    output logic [$clog2(DEPTH):0]   fifoCount
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int AW = $clog2(STARVE_LIMIT + 1);

    logic [4:0]        reg_q  [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic [AW-1:0]     age_q, age_d;
    logic              reg_write_q, reg_write_d;
    logic [4:0]        write_reg_q, write_reg_d;
    logic [DATA_W-1:0] write_data_q, write_data_d;

    logic fifo_ne, starve, pipe_hit, push, pop, issue_pipe;
    logic hit_a, hit_b;
    logic [PW-1:0] off;

    assign fifo_ne   = (count_q != '0);
    assign starve    = (age_q == AW'(STARVE_LIMIT));
    assign pipe_hit  = pipeValid && (pipeReg != 5'd0);
    assign longReady = (count_q != CW'(DEPTH));
    assign pipeReady = !starve;
    assign push      = longValid && longReady && (longReg != 5'd0);

    // Priority: starved head, then a real pipeline write, then any queued head.
    always_comb begin
        pop        = 1'b0;
        issue_pipe = 1'b0;
        if (starve && fifo_ne) begin
            pop = 1'b1;
        end else if (pipe_hit) begin
            issue_pipe = 1'b1;
        end else if (fifo_ne) begin
            pop = 1'b1;
        end
    end

    always_comb begin
        rd_ptr_d     = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
        wr_ptr_d     = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        count_d      = count_q;
        if (push && !pop) count_d = count_q + CW'(1);
        if (pop && !push) count_d = count_q - CW'(1);

        age_d = age_q;
        if (pop || !fifo_ne) begin
            age_d = '0;
        end else if (!starve) begin
            age_d = age_q + AW'(1);
        end

        reg_write_d  = pop || issue_pipe;
        write_reg_d  = write_reg_q;
        write_data_d = write_data_q;
        if (pop) begin
            write_reg_d  = reg_q[rd_ptr_q];
            write_data_d = data_q[rd_ptr_q];
        end else if (issue_pipe) begin
            write_reg_d  = pipeReg;
            write_data_d = pipeData;
        end
    end

    // Only occupied slots count; the entry already in the output register is excluded.
    always_comb begin
        hit_a = 1'b0;
        hit_b = 1'b0;
        off   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            off = PW'(i) - rd_ptr_q;
            if ({1'b0, off} < count_q) begin
                if (reg_q[i] == srcA) hit_a = 1'b1;
                if (reg_q[i] == srcB) hit_b = 1'b1;
            end
        end
    end

    assign hazardA = hit_a && (srcA != 5'd0);
    assign hazardB = hit_b && (srcB != 5'd0);

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            for (int i = 0; i < DEPTH; i++) begin
                reg_q[i]  <= '0;
                data_q[i] <= '0;
            end
        end else if (push) begin
            reg_q[wr_ptr_q]  <= longReg;
            data_q[wr_ptr_q] <= longData;
        end
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            count_q      <= '0;
            age_q        <= '0;
            reg_write_q  <= 1'b0;
            write_reg_q  <= '0;
            write_data_q <= '0;
        end else begin
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            count_q      <= count_d;
            age_q        <= age_d;
            reg_write_q  <= reg_write_d;
            write_reg_q  <= write_reg_d;
            write_data_q <= write_data_d;
        end
    end

    assign regWrite  = reg_write_q;
    assign writeReg  = write_reg_q;
    assign writeData = write_data_q;
    assign fifoCount = count_q;

endmodule
